// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues one request/response transaction per fetch
// address and queues fetched words (or misaligned-fetch markers) for decode.
module inst_fetch_unit #(
   parameter int BUF_DEPTH = 2,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic              busy,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [31:0]       inst_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_inst,
   output logic [ADDR_W-1:0] id_pc,
   output logic              id_adel
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_REQ       = 3'd1;
   localparam logic [2:0] S_WAIT      = 3'd2;
   localparam logic [2:0] S_DROP_REQ  = 3'd3;
   localparam logic [2:0] S_DROP_WAIT = 3'd4;

   logic [2:0]        state_r;
   logic [2:0]        state_s;
   logic [ADDR_W-1:0] req_addr_r;
   logic [ADDR_W-1:0] req_pc_r;
   logic              inst_req_r;

   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [ADDR_W-1:0] mem_pc_r   [BUF_DEPTH];
   logic [31:0]       mem_inst_r [BUF_DEPTH];
   logic              mem_adel_r [BUF_DEPTH];

   logic              pc_aligned_s;
   logic              pop_s;
   logic              space_s;
   logic [CNT_W-1:0]  count_after_s;
   logic              latch_s;
   logic              push_s;
   logic [ADDR_W-1:0] push_pc_s;
   logic [31:0]       push_inst_s;
   logic              push_adel_s;
   logic              busy_s;

   assign pc_aligned_s  = (pc[1:0] == 2'b00);
   assign pop_s         = (count_r != {CNT_W{1'b0}}) && id_ready;
   assign space_s       = (count_r < DEPTH_C);
   assign count_after_s = count_r + CNT_W'(1) - CNT_W'(pop_s);

   // Next-state, push and busy decode; flush overrides all other events.
   always_comb begin
      state_s     = state_r;
      latch_s     = 1'b0;
      push_s      = 1'b0;
      push_pc_s   = pc;
      push_inst_s = 32'h0;
      push_adel_s = 1'b0;
      busy_s      = 1'b1;
      if (flush) begin
         busy_s = 1'b0;
         case (state_r)
            S_IDLE:      state_s = S_IDLE;
            S_REQ:       state_s = inst_addr_ok ? S_DROP_WAIT : S_DROP_REQ;
            S_WAIT:      state_s = inst_data_ok ? S_IDLE : S_DROP_WAIT;
            S_DROP_REQ:  state_s = inst_addr_ok ? S_DROP_WAIT : S_DROP_REQ;
            S_DROP_WAIT: state_s = inst_data_ok ? S_IDLE : S_DROP_WAIT;
            default:     state_s = S_IDLE;
         endcase
      end else begin
         case (state_r)
            S_IDLE: begin
               if (space_s) begin
                  if (!pc_aligned_s) begin
                     push_s      = 1'b1;
                     push_adel_s = 1'b1;
                     busy_s      = 1'b0;
                  end else begin
                     latch_s = 1'b1;
                     state_s = S_REQ;
                  end
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_REQ: begin
               if (inst_addr_ok) begin
                  busy_s  = 1'b0;
                  state_s = S_WAIT;
               end else begin
                  state_s = S_REQ;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  push_s      = 1'b1;
                  push_pc_s   = req_pc_r;
                  push_inst_s = inst_rdata;
                  // Chain the next fetch directly when the buffer still has room.
                  if ((count_after_s < DEPTH_C) && pc_aligned_s) begin
                     latch_s = 1'b1;
                     state_s = S_REQ;
                  end else begin
                     state_s = S_IDLE;
                  end
               end else begin
                  state_s = S_WAIT;
               end
            end
            S_DROP_REQ:  state_s = inst_addr_ok ? S_DROP_WAIT : S_DROP_REQ;
            S_DROP_WAIT: state_s = inst_data_ok ? S_IDLE : S_DROP_WAIT;
            default:     state_s = S_IDLE;
         endcase
      end
   end

   assign busy = busy_s | reset;

   // Fetch FSM, request address/PC latch and registered bus request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_IDLE;
         req_addr_r <= {ADDR_W{1'b0}};
         req_pc_r   <= {ADDR_W{1'b0}};
         inst_req_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         inst_req_r <= (state_s == S_REQ) || (state_s == S_DROP_REQ);
         if (latch_s) begin
            req_addr_r <= {pc[ADDR_W-1:2], 2'b00};
            req_pc_r   <= pc;
         end
      end
   end

   // FIFO pointers and occupancy; flush empties the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // FIFO storage; contents are only visible through a valid head.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_pc_r[wr_ptr_r]   <= push_pc_s;
         mem_inst_r[wr_ptr_r] <= push_inst_s;
         mem_adel_r[wr_ptr_r] <= push_adel_s;
      end
   end

   assign inst_req  = inst_req_r;
   assign inst_addr = req_addr_r;
   assign id_valid  = (count_r != {CNT_W{1'b0}});
   assign id_pc     = id_valid ? mem_pc_r[rd_ptr_r]   : {ADDR_W{1'b0}};
   assign id_inst   = id_valid ? mem_inst_r[rd_ptr_r] : 32'h0;
   assign id_adel   = id_valid ? mem_adel_r[rd_ptr_r] : 1'b0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with literal expectations,
// then randomized bus/decode/flush traffic checked against a queue model.
module tb_inst_fetch_unit;

   localparam int DEPTH = 2;
   localparam logic [31:0] VEC = 32'hbfc00380;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = 32'h0;
   logic        flush = 1'b0;
   logic        busy;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_adel;

   inst_fetch_unit #(.BUF_DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .pc(pc), .flush(flush), .busy(busy),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_valid(id_valid),
      .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } ent_t;

   // Reference model: one bus transaction tracked as flags, plus a queue of entries.
   ent_t        q[$];
   bit          m_req_active;
   bit          m_data_wait;
   bit          m_drop;
   logic [31:0] m_req_addr;
   logic [31:0] m_req_pc;

   int vectors = 0;
   int miscompares = 0;
   logic busy_seen;
   bit   last_exp_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_req_active = 1'b0;
      m_data_wait  = 1'b0;
      m_drop       = 1'b0;
      m_req_addr   = 32'h0;
      m_req_pc     = 32'h0;
   endtask

   function automatic bit exp_busy();
      bit idle;
      idle = !m_req_active && !m_data_wait;
      if (reset) return 1'b1;
      if (flush) return 1'b0;
      if (idle && (q.size() < DEPTH) && (pc[1:0] != 2'b00)) return 1'b0;
      if (m_req_active && !m_drop && inst_addr_ok) return 1'b0;
      return 1'b1;
   endfunction

   task automatic issue();
      m_req_active = 1'b1;
      m_drop       = 1'b0;
      m_req_addr   = {pc[31:2], 2'b00};
      m_req_pc     = pc;
   endtask

   task automatic model_step();
      int   sz0;
      bit   pop;
      ent_t e;
      if (reset) begin
         model_reset();
         return;
      end
      sz0 = q.size();
      pop = (sz0 > 0) && id_ready;
      if (flush) begin
         q.delete();
         if (m_req_active) begin
            m_drop = 1'b1;
            if (inst_addr_ok) begin
               m_req_active = 1'b0;
               m_data_wait  = 1'b1;
            end
         end else if (m_data_wait) begin
            if (inst_data_ok) begin
               m_data_wait = 1'b0;
               m_drop      = 1'b0;
            end else begin
               m_drop = 1'b1;
            end
         end
      end else begin
         if (pop) void'(q.pop_front());
         if (!m_req_active && !m_data_wait) begin
            if (sz0 < DEPTH) begin
               if (pc[1:0] != 2'b00) begin
                  e = '{pc: pc, inst: 32'h0, adel: 1'b1};
                  q.push_back(e);
               end else begin
                  issue();
               end
            end
         end else if (m_req_active) begin
            if (inst_addr_ok) begin
               m_req_active = 1'b0;
               m_data_wait  = 1'b1;
            end
         end else if (inst_data_ok) begin
            m_data_wait = 1'b0;
            if (m_drop) begin
               m_drop = 1'b0;
            end else begin
               e = '{pc: m_req_pc, inst: inst_rdata, adel: 1'b0};
               q.push_back(e);
               if ((q.size() < DEPTH) && (pc[1:0] == 2'b00)) issue();
            end
         end
      end
   endtask

   task automatic compare_all();
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      last_exp_busy = exp_busy();
      check("busy", {31'h0, busy}, {31'h0, last_exp_busy});
      check("inst_req", {31'h0, inst_req}, {31'h0, m_req_active});
      check("inst_addr", inst_addr, m_req_addr);
      check("id_valid", {31'h0, id_valid}, {31'h0, (q.size() > 0)});
      check("id_pc", id_pc, h.pc);
      check("id_inst", id_inst, h.inst);
      check("id_adel", {31'h0, id_adel}, {31'h0, h.adel});
   endtask

   // One clock: drive inputs, compare on the falling edge, advance the model at the rising edge.
   task automatic cyc(input logic [31:0] p, input logic f, input logic ao, input logic dok,
                      input logic [31:0] rd, input logic rdy);
      pc = p; flush = f; inst_addr_ok = ao; inst_data_ok = dok; inst_rdata = rd; id_ready = rdy;
      if (reset) model_reset();
      @(negedge clk);
      busy_seen = busy;
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] cur_pc;
      logic        f, ao, dok, rdy;
      model_reset();
      #1;
      do_reset();
      check("rst_busy", {31'h0, busy_seen}, 32'h1);
      check("rst_id_valid", {31'h0, id_valid}, 32'h0);

      // Basic fetch, then back-to-back issue.
      cyc(32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t2_busy_req", {31'h0, busy_seen}, 32'h1);
      check("t2_inst_addr", inst_addr, 32'hbfc00000);
      cyc(32'hbfc00000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t2_busy_addr_ok", {31'h0, busy_seen}, 32'h0);
      cyc(32'hbfc00004, 1'b0, 1'b0, 1'b1, 32'h24080001, 1'b0);
      check("t2_busy_data_ok", {31'h0, busy_seen}, 32'h1);
      check("t2_id_valid", {31'h0, id_valid}, 32'h1);
      check("t2_id_pc", id_pc, 32'hbfc00000);
      check("t2_id_inst", id_inst, 32'h24080001);
      check("t2_next_addr", inst_addr, 32'hbfc00004);

      // Fill the FIFO with decode stalled, then release one entry.
      cyc(32'hbfc00004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(32'hbfc00008, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
      cyc(32'hbfc00008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t3_full_busy", {31'h0, busy_seen}, 32'h1);
      check("t3_full_req", {31'h0, inst_req}, 32'h0);
      cyc(32'hbfc00008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("t3_pop_head", id_pc, 32'hbfc00004);
      cyc(32'hbfc00008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t3_resume_req", {31'h0, inst_req}, 32'h1);
      check("t3_resume_addr", inst_addr, 32'hbfc00008);

      // Reset while waiting for data; late data must be ignored.
      cyc(32'hbfc00008, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      cyc(32'hbfc0000c, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t1_req", {31'h0, inst_req}, 32'h0);
      check("t1_id_valid", {31'h0, id_valid}, 32'h0);
      check("t1_busy", {31'h0, busy_seen}, 32'h1);
      reset = 1'b0;
      cyc(32'hbfc0000c, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
      check("t1_late_busy", {31'h0, busy_seen}, 32'h1);
      check("t1_late_valid", {31'h0, id_valid}, 32'h0);

      // Misaligned fetch becomes an exception entry without a bus request.
      do_reset();
      cyc(32'hbfc00002, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t4_busy", {31'h0, busy_seen}, 32'h0);
      check("t4_req", {31'h0, inst_req}, 32'h0);
      check("t4_adel", {31'h0, id_adel}, 32'h1);
      check("t4_pc", id_pc, 32'hbfc00002);
      check("t4_inst", id_inst, 32'h0);

      // Flush while waiting for data.
      do_reset();
      cyc(32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(32'hbfc00000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(32'hbfc00004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_flush_busy", {31'h0, busy_seen}, 32'h0);
      cyc(VEC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(VEC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_no_issue", {31'h0, inst_req}, 32'h0);
      cyc(VEC, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b1);
      check("t5_discard", {31'h0, id_valid}, 32'h0);
      check("t5_no_issue2", {31'h0, inst_req}, 32'h0);
      cyc(VEC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_new_req", {31'h0, inst_req}, 32'h1);
      check("t5_new_addr", inst_addr, VEC);

      // Flush while the request is still unaccepted.
      do_reset();
      cyc(32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(32'hbfc00000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t6_flush_busy", {31'h0, busy_seen}, 32'h0);
      cyc(VEC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t6_hold_req", {31'h0, inst_req}, 32'h1);
      check("t6_hold_addr", inst_addr, 32'hbfc00000);
      cyc(VEC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t6_drop_busy", {31'h0, busy_seen}, 32'h1);
      cyc(VEC, 1'b0, 1'b0, 1'b1, 32'h0000ffff, 1'b1);
      check("t6_no_valid", {31'h0, id_valid}, 32'h0);

      // Randomized traffic; the PC advances whenever the model says it may.
      do_reset();
      cur_pc = 32'hbfc00000;
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 500) begin
            do_reset();
            cur_pc = 32'hbfc00000;
         end
         f   = ($urandom_range(0, 29) == 0);
         ao  = $urandom_range(0, 1) == 1;
         dok = m_data_wait ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         cyc(cur_pc, f, ao, dok, $urandom, rdy);
         if (!last_exp_busy) begin
            if (f) begin
               cur_pc = VEC;
            end else begin
               cur_pc = ((cur_pc & 32'hfffffffc) + 32'd4) |
                        (($urandom_range(0, 19) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
